// File: rtl/byte_ram_ctrl.sv
// Byte-lane RAM with per-byte write strobes, 1-cycle registered reads (write-first
// on collision) and a self-clearing INIT sweep that zeroes every word after reset or clr_i.
module byte_ram_ctrl #(
  parameter int DW  = 32,
  parameter int AW  = 12,
  parameter int OFS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic [DW/8-1:0] wen_i,
  input  logic [31:0]   w_addr_i,
  input  logic [DW-1:0] w_data_i,
  input  logic          ren_i,
  input  logic [31:0]   r_addr_i,
  output logic [DW-1:0] r_data_o,
  output logic          r_valid_o,
  output logic          busy_o
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {INIT, IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   w_idx, r_idx;
  logic [DW-1:0]   rd_word;
  logic            in_init;

  // Upper address bits wrap the index; low bits address bytes within the word.
  assign w_idx   = w_addr_i[AW+OFS-1:OFS];
  assign r_idx   = r_addr_i[AW+OFS-1:OFS];
  assign in_init = (state_q == INIT);
  assign busy_o  = in_init;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr_i[31:AW+OFS], w_addr_i[OFS-1:0],
                              r_addr_i[31:AW+OFS], r_addr_i[OFS-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = IDLE;
      end
      IDLE: begin
        if (clr_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  for (genvar k = 0; k < NB; k++) begin : g_lane
    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset; the INIT sweep zeroes it word by word.
    always_ff @(posedge clk) begin
      if (in_init)
        mem[cnt_q] <= '0;
      else if (wen_i[k])
        mem[w_idx] <= w_data_i[8*k +: 8];
    end

    // Write-first bypass: a same-cycle write to the read word wins on its lanes.
    assign rd_word[8*k +: 8] = (wen_i[k] && (w_idx == r_idx)) ? w_data_i[8*k +: 8]
                                                              : mem[r_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else begin
      r_valid_o <= !in_init && ren_i;
      if (!in_init && ren_i) r_data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Scoreboard bench for byte_ram_ctrl (DW=32, AW=4): directed reads push expected
// words; a negedge monitor pops and compares on every r_valid_o pulse.
module tb_byte_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [3:0]  wen;
  logic [31:0] w_addr, w_data, r_addr;
  logic        ren;
  logic [31:0] r_data;
  logic        r_valid, busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  byte_ram_ctrl #(.DW(32), .AW(4), .OFS(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .wen_i(wen), .w_addr_i(w_addr),
    .w_data_i(w_data), .ren_i(ren), .r_addr_i(r_addr), .r_data_o(r_data),
    .r_valid_o(r_valid), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && r_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_r_valid", 32'(r_valid), 32'h0);
      end else begin
        check("read_data", r_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; wen = 0; w_addr = 0; w_data = 0; ren = 0; r_addr = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    idle(); wen = s; w_addr = a; w_data = d; tick(); idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    idle(); ren = 1; r_addr = a; exp_q.push_back(e); tick(); idle();
  endtask

  task automatic wait_busy_fall(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    tick(); tick();
    check("reset_busy", 32'(busy), 32'h1);
    check("reset_r_valid", 32'(r_valid), 32'h0);
    check("reset_r_data", r_data, 32'h0);
    rst_n = 1;
    wait_busy_fall("initial_clear_edges");

    // Back-to-back reads of every word after the sweep: all zero, no bubbles.
    ren = 1;
    for (int i = 0; i < 16; i++) begin
      r_addr = 32'(i * 4);
      exp_q.push_back(32'h0);
      tick();
      check("b2b_valid", 32'(r_valid), 32'h1);
    end
    idle();

    // Partial-strobe merge and single-cycle valid pulse.
    wr(32'h08, 4'hF, 32'hDEADBEEF);
    wr(32'h08, 4'b0010, 32'h00005500);
    rd(32'h08, 32'hDEAD55EF);
    tick();
    check("valid_one_cycle", 32'(r_valid), 32'h0);
    check("r_data_hold", r_data, 32'hDEAD55EF);

    // Write-first collision on word 3.
    wr(32'h0C, 4'hF, 32'h11223344);
    idle(); wen = 4'b1001; w_addr = 32'h0C; w_data = 32'hAABBCCDD;
    ren = 1; r_addr = 32'h0C; exp_q.push_back(32'hAA2233DD); tick(); idle();
    rd(32'h0C, 32'hAA2233DD);

    // Address wrap, ignored byte-offset bits, and independent read/write words.
    wr(32'h44, 4'hF, 32'h12345678);
    rd(32'h04, 32'h12345678);
    rd(32'hFFFF_FF0B, 32'hDEAD55EF);
    idle(); wen = 4'hF; w_addr = 32'h14; w_data = 32'hCAFEF00D;
    ren = 1; r_addr = 32'h08; exp_q.push_back(32'hDEAD55EF); tick(); idle();
    rd(32'h14, 32'hCAFEF00D);
    rd(32'h08, 32'hDEAD55EF);
    wr(32'h08, 4'h0, 32'hFFFFFFFF);
    rd(32'h08, 32'hDEAD55EF);

    // Clear with a same-cycle read; traffic during the sweep must be ignored.
    idle(); clr = 1; ren = 1; r_addr = 32'h08; exp_q.push_back(32'hDEAD55EF); tick();
    for (int i = 0; i < 16; i++) begin
      check("clr_busy", 32'(busy), 32'h1);
      clr = 1; ren = 1; r_addr = 32'h08; wen = 4'hF; w_addr = 32'h08; w_data = 32'hFFFFFFFF;
      tick();
    end
    idle();
    check("clr_done", 32'(busy), 32'h0);
    check("clr_r_data_hold", r_data, 32'hDEAD55EF);
    rd(32'h08, 32'h0);
    rd(32'h0C, 32'h0);
    rd(32'h04, 32'h0);

    // Reset in the middle of a sweep restarts the full clear.
    wr(32'h04, 4'hF, 32'h0A0B0C0D);
    rd(32'h04, 32'h0A0B0C0D);
    idle(); clr = 1; tick(); idle();
    for (int i = 0; i < 7; i++) tick();
    rst_n = 0;
    #1;
    check("mid_reset_r_data", r_data, 32'h0);
    check("mid_reset_busy", 32'(busy), 32'h1);
    tick();
    rst_n = 1;
    wait_busy_fall("restart_clear_edges");
    rd(32'h04, 32'h0);

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
